// File: rtl/zcr_counter.sv
// Zero-crossing-rate counter for one I2S channel, with hysteresis and a per-frame count.
// Optional ZCR_ENERGY_EN adds zcr_energy, the sum of |sample| over each frame.
module zcr_counter #(
  parameter int DATA_WIDTH = 32,
  parameter int SAMPLE_W   = 18,
  parameter int FRAME_LEN  = 64,
  parameter int CNT_W      = 6,
  parameter int THRESH     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_vld,
  output logic [CNT_W-1:0]      zcr_count,
  output logic                  zcr_valid,
`ifdef ZCR_ENERGY_EN
  output logic [SAMPLE_W+$clog2(FRAME_LEN)-1:0] zcr_energy,
`endif
  output logic                  zcr_sat
);

  localparam int FRM_W = $clog2(FRAME_LEN);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // One extra bit keeps -THRESH and the most negative sample representable.
  localparam logic signed [SAMPLE_W:0] THR_P = (SAMPLE_W + 1)'(THRESH);
  localparam logic signed [SAMPLE_W:0] THR_N = -THR_P;

  typedef enum logic [1:0] {
    S_UNK = 2'd0,
    S_POS = 2'd1,
    S_NEG = 2'd2
  } sign_state_e;

  sign_state_e             state_r;
  sign_state_e             state_nxt_s;
  logic [FRM_W-1:0]        frame_cnt_r;
  logic [CNT_W-1:0]        run_cnt_r;
  logic                    sat_r;
  logic signed [SAMPLE_W:0] samp_ext_s;
  logic                    above_s;
  logic                    below_s;
  logic                    cross_s;
  logic                    last_s;
  logic [CNT_W-1:0]        cnt_inc_s;
  logic                    sat_inc_s;

  // Only the MSB-aligned sample bits matter; the rest of the word is ignored.
  if (DATA_WIDTH > SAMPLE_W) begin : g_low_bits
    logic unused_low_s;
    assign unused_low_s = ^in_data[DATA_WIDTH-SAMPLE_W-1:0];
  end

  // Sample extraction and strict dead-band comparison.
  always_comb begin
    samp_ext_s = {in_data[DATA_WIDTH-1], in_data[DATA_WIDTH-1 -: SAMPLE_W]};
    above_s    = (samp_ext_s > THR_P);
    below_s    = (samp_ext_s < THR_N);
    last_s     = (frame_cnt_r == FRM_LAST);
  end

  // Sign state transition and crossing detection.
  always_comb begin
    state_nxt_s = state_r;
    cross_s     = 1'b0;
    case (state_r)
      S_UNK: begin
        if (above_s) begin
          state_nxt_s = S_POS;
        end else if (below_s) begin
          state_nxt_s = S_NEG;
        end else begin
          state_nxt_s = S_UNK;
        end
      end
      S_POS: begin
        if (below_s) begin
          state_nxt_s = S_NEG;
          cross_s     = 1'b1;
        end else begin
          state_nxt_s = S_POS;
        end
      end
      S_NEG: begin
        if (above_s) begin
          state_nxt_s = S_POS;
          cross_s     = 1'b1;
        end else begin
          state_nxt_s = S_NEG;
        end
      end
      default: begin
        state_nxt_s = S_UNK;
        cross_s     = 1'b0;
      end
    endcase
  end

  // Saturating running count; sat sticks once an increment is attempted at max.
  always_comb begin
    if (cross_s && (run_cnt_r != CNT_MAX)) begin
      cnt_inc_s = run_cnt_r + CNT_W'(1);
    end else begin
      cnt_inc_s = run_cnt_r;
    end
    sat_inc_s = sat_r | (cross_s & (run_cnt_r == CNT_MAX));
  end

  // FSM, frame counter, running count and registered frame results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_UNK;
      frame_cnt_r <= {FRM_W{1'b0}};
      run_cnt_r   <= {CNT_W{1'b0}};
      sat_r       <= 1'b0;
      zcr_count   <= {CNT_W{1'b0}};
      zcr_sat     <= 1'b0;
      zcr_valid   <= 1'b0;
    end else begin
      zcr_valid <= 1'b0;
      if (in_vld) begin
        state_r <= state_nxt_s;
        if (last_s) begin
          frame_cnt_r <= {FRM_W{1'b0}};
          run_cnt_r   <= {CNT_W{1'b0}};
          sat_r       <= 1'b0;
          zcr_count   <= cnt_inc_s;
          zcr_sat     <= sat_inc_s;
          zcr_valid   <= 1'b1;
        end else begin
          frame_cnt_r <= frame_cnt_r + FRM_W'(1);
          run_cnt_r   <= cnt_inc_s;
          sat_r       <= sat_inc_s;
        end
      end
    end
  end

`ifdef ZCR_ENERGY_EN
  localparam int ENG_W = SAMPLE_W + FRM_W;

  logic [SAMPLE_W:0] mag_s;
  logic [ENG_W-1:0]  eng_acc_r;
  logic [ENG_W-1:0]  eng_inc_s;

  // Magnitude in SAMPLE_W+1 bits so the most negative sample does not wrap.
  always_comb begin
    if (samp_ext_s[SAMPLE_W]) begin
      mag_s = -samp_ext_s;
    end else begin
      mag_s = samp_ext_s;
    end
    eng_inc_s = eng_acc_r + ENG_W'(mag_s);
  end

  // Energy accumulator, published and cleared alongside zcr_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_acc_r  <= {ENG_W{1'b0}};
      zcr_energy <= {ENG_W{1'b0}};
    end else if (in_vld) begin
      if (last_s) begin
        eng_acc_r  <= {ENG_W{1'b0}};
        zcr_energy <= eng_inc_s;
      end else begin
        eng_acc_r  <= eng_inc_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_zcr_counter.sv
// Directed self-checking bench for zcr_counter (default parameters, THRESH=64).
// Energy checks are compiled in when ZCR_ENERGY_EN is defined.
module tb_zcr_counter;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_vld;
  logic [5:0]  zcr_count;
  logic        zcr_valid;
  logic        zcr_sat;
`ifdef ZCR_ENERGY_EN
  logic [23:0] zcr_energy;
`endif

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;

  zcr_counter dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .zcr_count (zcr_count),
    .zcr_valid (zcr_valid),
`ifdef ZCR_ENERGY_EN
    .zcr_energy(zcr_energy),
`endif
    .zcr_sat   (zcr_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count valid pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (zcr_valid === 1'b1) vcnt <= vcnt + 1;
  end

  // One strobe, starting and ending on a negedge; low bits carry junk.
  task automatic drive(input logic signed [17:0] s);
    in_data = {s, 14'($urandom)};
    in_vld  = 1'b1;
    @(negedge clk);
    in_vld  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    in_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
  endtask

  // Checks the frame result exactly one clock after the final strobe, then the pulse drop.
  task automatic check_frame(input string name, input logic [5:0] ecnt, input logic esat);
    checks++;
    if (zcr_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b want 1", name, zcr_valid);
    end
    checks++;
    if (zcr_count !== ecnt) begin
      errors++;
      $display("FAIL %s count: got %0d want %0d", name, zcr_count, ecnt);
    end
    checks++;
    if (zcr_sat !== esat) begin
      errors++;
      $display("FAIL %s sat: got %b want %b", name, zcr_sat, esat);
    end
    @(negedge clk);
    checks++;
    if (zcr_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_drop: got %b want 0", name, zcr_valid);
    end
    checks++;
    if (zcr_count !== ecnt) begin
      errors++;
      $display("FAIL %s count_hold: got %0d want %0d", name, zcr_count, ecnt);
    end
  endtask

  task automatic check_vcnt(input string name, input int want);
    checks++;
    if (vcnt !== want) begin
      errors++;
      $display("FAIL %s pulses: got %0d want %0d", name, vcnt, want);
    end
  endtask

  task automatic check_energy(input string name, input logic [23:0] want);
`ifdef ZCR_ENERGY_EN
    checks++;
    if (zcr_energy !== want) begin
      errors++;
      $display("FAIL %s energy: got %0d want %0d", name, zcr_energy, want);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (zcr_count !== 6'd0) begin errors++; $display("FAIL reset count: got %0d want 0", zcr_count); end
    checks++;
    if (zcr_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", zcr_valid); end
    checks++;
    if (zcr_sat !== 1'b0) begin errors++; $display("FAIL reset sat: got %b want 0", zcr_sat); end
    check_energy("reset", 24'd0);
  endtask

  task automatic test_constant();
    int v0;
    v0 = vcnt;
    for (int i = 0; i < 63; i++) drive(18'sd1000);
    check_vcnt("const_early", v0);
    drive(18'sd1000);
    check_energy("const", 24'd64000);
    check_frame("const", 6'd0, 1'b0);
    check_vcnt("const_once", v0 + 1);
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 64; i++) drive((i % 2 == 0) ? 18'sd1000 : -18'sd1000);
    check_energy("alt1", 24'd64000);
    check_frame("alt1", 6'd63, 1'b0);
    for (int i = 0; i < 64; i++) drive((i % 2 == 0) ? 18'sd1000 : -18'sd1000);
    check_frame("alt2_sat", 6'd63, 1'b1);
  endtask

  task automatic test_dead_band();
    do_reset();
    drive(18'sd100);
    drive(18'sd64);
    drive(-18'sd64);
    drive(-18'sd65);
    drive(18'sd30);
    drive(18'sd65);
    for (int i = 0; i < 58; i++) drive(18'sd100);
    check_energy("deadband", 24'd6188);
    check_frame("deadband", 6'd2, 1'b0);
  endtask

  task automatic test_extremes();
    do_reset();
    for (int i = 0; i < 64; i++) drive((i % 2 == 0) ? -18'sd131072 : 18'sd131071);
    check_energy("extreme", 24'd8388576);
    check_frame("extreme", 6'd63, 1'b0);
  endtask

  task automatic test_reset_mid();
    int v0;
    do_reset();
    v0 = vcnt;
    for (int i = 0; i < 40; i++) drive((i % 2 == 0) ? 18'sd1000 : -18'sd1000);
    // Reset coincides with a strobe; the strobe must be discarded.
    in_data = {18'sd1000, 14'd0};
    in_vld  = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    in_vld  = 1'b0;
    rst     = 1'b0;
    for (int i = 0; i < 64; i++) drive(-18'sd500);
    check_vcnt("rstmid_none", v0);
    check_energy("rstmid", 24'd32000);
    check_frame("rstmid", 6'd0, 1'b0);
  endtask

  task automatic test_back_to_back_gaps();
    int v0;
    do_reset();
    v0 = vcnt;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 64; i++) begin
        drive((i % 2 == 0) ? 18'sd200 : -18'sd200);
        if (i != 63) begin
          repeat ($urandom_range(5, 0)) @(negedge clk);
        end
      end
      check_energy("gaps", 24'd12800);
      check_frame((f == 0) ? "gaps_first" : "gaps_sat", 6'd63, (f == 0) ? 1'b0 : 1'b1);
      repeat ($urandom_range(5, 0)) @(negedge clk);
    end
    check_vcnt("gaps_total", v0 + 5);
  endtask

  initial begin
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_data = 32'd0;
    test_reset();
    test_constant();
    test_alternate();
    test_dead_band();
    test_extremes();
    test_reset_mid();
    test_back_to_back_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
